// File: rtl/i2c_controller.sv
// Single-byte I2C controller: START, {dev_addr,rw} + ACK, one data byte + ACK/NACK, STOP.
// Latency: done 80*CLK_DIV cycles after accept (44*CLK_DIV on address NACK); SCL period 4*CLK_DIV.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, nothing is queued.
module i2c_controller #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
    S_WACK, S_RDATA, S_RNACK, S_STOP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    q, q_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    addr_byte, wdat, rx_sh;
  logic          smp;
  logic          running, qtick, accept;
  logic          scl_n, sda_n, slot_scl;
  logic          err_set, rd_load;

  assign running  = (state != S_IDLE) && (state != S_DONE);
  assign qtick    = running && (cnt == CW'(CLK_DIV - 1));
  assign accept   = (state == S_IDLE) && start;
  // Within a bit slot SCL is high only in the middle two quarters.
  assign slot_scl = q_n[0] ^ q_n[1];

  // State, quarter index, bit counter and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      bit_cnt <= bit_cnt_n;
      if (qtick || !running) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
    end
  end

  // Next-state: transitions happen only at the end of a slot (last quarter tick).
  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_cnt_n = bit_cnt;
    err_set   = 1'b0;
    rd_load   = 1'b0;
    if (accept) begin
      state_n   = S_START;
      q_n       = 2'd0;
      bit_cnt_n = 3'd0;
    end else if (state == S_DONE) begin
      state_n = S_IDLE;
    end else if (qtick) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        case (state)
          S_START: state_n = S_ADDR;
          S_ADDR: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_ADDR_ACK;
          end
          S_ADDR_ACK: begin
            if (smp) begin
              err_set = 1'b1;
              state_n = S_STOP;
            end else begin
              state_n = addr_byte[0] ? S_RDATA : S_WDATA;
            end
          end
          S_WDATA: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_WACK;
          end
          S_WACK: begin
            err_set = smp;
            state_n = S_STOP;
          end
          S_RDATA: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rd_load = 1'b1;
              state_n = S_RNACK;
            end
          end
          S_RNACK: state_n = S_STOP;
          S_STOP:  state_n = S_DONE;
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  // Pad values for the upcoming cycle; data bits only move when bit_cnt moves, i.e. on q0 entry.
  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      S_START: sda_n = ~q_n[1];
      S_STOP: begin
        scl_n = (q_n != 2'd0);
        sda_n = (q_n == 2'd3);
      end
      S_ADDR: begin
        scl_n = slot_scl;
        sda_n = addr_byte[3'd7 - bit_cnt_n];
      end
      S_WDATA: begin
        scl_n = slot_scl;
        sda_n = wdat[3'd7 - bit_cnt_n];
      end
      S_ADDR_ACK, S_WACK, S_RDATA, S_RNACK: scl_n = slot_scl;
      default: ;
    endcase
  end

  // Registered open-drain controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_out <= 1'b1;
      sda_out <= 1'b1;
    end else begin
      scl_out <= scl_n;
      sda_out <= sda_n;
    end
  end

  // Request latch and SDA sampling on entry to q2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_byte <= 8'h00;
      wdat      <= 8'h00;
      rx_sh     <= 8'h00;
      smp       <= 1'b1;
    end else begin
      if (accept) begin
        addr_byte <= {dev_addr, rw};
        wdat      <= wr_data;
      end
      if (qtick && q == 2'd1) begin
        smp <= sda_in;
        if (state == S_RDATA) rx_sh <= {rx_sh[6:0], sda_in};
      end
    end
  end

  // Status: busy/done handshake, sticky-per-transaction ack_err, read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      done <= (state_n == S_DONE);
      if (accept)                 busy <= 1'b1;
      else if (state_n == S_DONE) busy <= 1'b0;
      if (accept)       ack_err <= 1'b0;
      else if (err_set) ack_err <= 1'b1;
      if (rd_load) rd_data <= rx_sh;
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: two instances (CLK_DIV=4 and CLK_DIV=2) share one bus-level
// subordinate model; a vector table drives whole transactions, hand sequences cover
// ignored requests while busy and reset in the middle of a data byte.
module tb_i2c_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [6:0] dev_addr;
  logic [7:0] wr_data;
  logic       sel;

  logic       a_scl, a_sda, a_busy, a_done, a_err;
  logic [7:0] a_rd;
  logic       b_scl, b_sda, b_busy, b_done, b_err;
  logic [7:0] b_rd;

  // Subordinate configuration (written by the stimulus only).
  logic       ack_addr, ack_data;
  logic [7:0] rd_byte;

  // Subordinate model state (written by the model only).
  logic       sub_sda = 1'b1;
  logic       scl_q = 1'b1, sda_q = 1'b1;
  int         slot = 0, slots_seen = 0, n_start = 0, n_stop = 0;
  logic [7:0] addr_sh = 8'h00, data_sh = 8'h00;
  logic       ack1 = 1'b1, ack2 = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  wire start_a  = start & ~sel;
  wire start_b  = start & sel;
  wire a_sda_in = a_sda & sub_sda;
  wire b_sda_in = b_sda & sub_sda;
  wire scl_bus  = sel ? b_scl : a_scl;
  wire sda_bus  = sel ? b_sda_in : a_sda_in;
  wire       m_busy = sel ? b_busy : a_busy;
  wire       m_done = sel ? b_done : a_done;
  wire       m_err  = sel ? b_err  : a_err;
  wire [7:0] m_rd   = sel ? b_rd   : a_rd;

  always #5 clk = ~clk;

  i2c_controller #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rw(rw), .dev_addr(dev_addr),
    .wr_data(wr_data), .sda_in(a_sda_in), .scl_out(a_scl), .sda_out(a_sda),
    .busy(a_busy), .done(a_done), .ack_err(a_err), .rd_data(a_rd)
  );

  i2c_controller #(.CLK_DIV(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rw(rw), .dev_addr(dev_addr),
    .wr_data(wr_data), .sda_in(b_sda_in), .scl_out(b_scl), .sda_out(b_sda),
    .busy(b_busy), .done(b_done), .ack_err(b_err), .rd_data(b_rd)
  );

  // What the subordinate drives in slot s (0..7 address, 8 addr ack, 9..16 data, 17 data ack).
  function automatic logic sub_drive(input int s);
    logic d;
    d = 1'b1;
    if (s == 8 && ack_addr) d = 1'b0;
    if (s >= 9 && s <= 16 && ack_addr && addr_sh[0]) d = rd_byte[16 - s];
    if (s == 17 && !addr_sh[0] && ack_data) d = 1'b0;
    return d;
  endfunction

  // Bus-level subordinate and protocol monitor, evaluated on the falling clock edge.
  always @(negedge clk) begin
    scl_q <= scl_bus;
    sda_q <= sda_bus;
    if (scl_bus && scl_q && sda_q && !sda_bus) begin
      n_start <= n_start + 1;
      slot    <= -1;
      sub_sda <= 1'b1;
    end else if (scl_bus && scl_q && !sda_q && sda_bus) begin
      n_stop     <= n_stop + 1;
      slots_seen <= slot;
    end else if (scl_bus && !scl_q) begin
      if (slot >= 0 && slot < 8)       addr_sh <= {addr_sh[6:0], sda_bus};
      else if (slot == 8)              ack1    <= sda_bus;
      else if (slot >= 9 && slot < 17) data_sh <= {data_sh[6:0], sda_bus};
      else if (slot == 17)             ack2    <= sda_bus;
    end else if (!scl_bus && scl_q) begin
      slot    <= slot + 1;
      sub_sda <= sub_drive(slot + 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] wr_data;
    logic       ack_addr;
    logic       ack_data;
    logic [7:0] rd_byte;
    logic       inject;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_ack2;
    int         exp_edges;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_slots;
  } vec_t;

  // One full transaction on the selected instance, with all end-of-transaction checks.
  task automatic run_txn(input vec_t v);
    int   s0, p0, n;
    logic got;
    ack_addr = v.ack_addr;
    ack_data = v.ack_data;
    rd_byte  = v.rd_byte;
    rw       = v.rw;
    dev_addr = v.dev_addr;
    wr_data  = v.wr_data;
    s0 = n_start;
    p0 = n_stop;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", m_busy, 1);
    chk("ack_err_cleared", m_err, 0);
    got = 1'b0;
    n = 0;
    while (!got && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (v.inject && n == 20) begin
        start    = 1'b1;
        rw       = ~v.rw;
        dev_addr = 7'h0F;
        wr_data  = 8'h11;
      end
      if (v.inject && n == 23) start = 1'b0;
      if (m_done) got = 1'b1;
    end
    chk("done_latency", got ? n : 0, v.exp_edges);
    chk("busy_low_with_done", m_busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", m_done, 0);
    chk("ack_err", m_err, v.exp_err);
    chk("rd_data", m_rd, v.exp_rd);
    chk("bus_addr_byte", addr_sh, v.exp_addr);
    chk("bus_addr_ack", ack1, !v.ack_addr);
    chk("bus_slots_before_stop", slots_seen, v.exp_slots);
    chk("start_conditions", n_start - s0, 1);
    chk("stop_conditions", n_stop - p0, 1);
    if (v.exp_slots == 18) begin
      chk("bus_data_byte", data_sh, v.exp_data);
      chk("bus_slot18_sda", ack2, v.exp_ack2);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vec_t vb, vr;
    int   s0;
    logic saw;

    //            rw    addr   wdata  aA    aD    rbyte  inj   eAddr  eData  eAck2 edges eErr  eRd    slots
    vecs[0] = '{1'b0, 7'h2A, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 8'h54, 8'h5A, 1'b0, 320, 1'b0, 8'h00, 18};
    vecs[1] = '{1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 8'h55, 8'hC3, 1'b1, 320, 1'b0, 8'hC3, 18};
    vecs[2] = '{1'b1, 7'h2A, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h55, 8'h00, 1'b1, 176, 1'b1, 8'hC3, 9};
    vecs[3] = '{1'b0, 7'h13, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h26, 8'hA5, 1'b1, 320, 1'b1, 8'hC3, 18};
    vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'hFF, 8'h3C, 1'b1, 320, 1'b0, 8'h3C, 18};
    vecs[5] = '{1'b0, 7'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 320, 1'b0, 8'h3C, 18};
    vb      = '{1'b0, 7'h51, 8'h96, 1'b1, 1'b1, 8'h00, 1'b1, 8'hA2, 8'h96, 1'b0, 160, 1'b0, 8'h00, 18};
    vr      = '{1'b0, 7'h2A, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 8'h54, 8'h5A, 1'b0, 320, 1'b0, 8'h00, 18};

    rst_n = 1'b0; start = 1'b0; rw = 1'b0; dev_addr = 7'h00; wr_data = 8'h00;
    sel = 1'b0; ack_addr = 1'b1; ack_data = 1'b1; rd_byte = 8'h00;

    repeat (3) @(posedge clk); #1;
    chk("reset_state_a", {a_scl, a_sda, a_busy, a_done, a_err, a_rd}, 13'h1800);
    chk("reset_state_b", {b_scl, b_sda, b_busy, b_done, b_err, b_rd}, 13'h1800);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Second request mid-transaction on the fast instance must leave no trace on the bus.
    sel = 1'b1;
    repeat (2) @(posedge clk); #1;
    run_txn(vb);
    s0  = n_start;
    saw = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (b_busy) saw = 1'b1;
    end
    chk("ignored_req_no_busy", saw, 0);
    chk("ignored_req_no_start", n_start - s0, 0);
    chk("ignored_req_addr", addr_sh, 8'hA2);

    // Reset during WDATA bit 3 (quarter 52, q0: SCL low, SDA = wr_data[4] = 0).
    sel = 1'b0;
    ack_addr = 1'b1; ack_data = 1'b1; rw = 1'b0; dev_addr = 7'h2A; wr_data = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (209) @(posedge clk);
    #1;
    chk("pre_reset_mid_byte", {a_scl, a_sda, a_busy}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {a_scl, a_sda, a_busy, a_done, a_err}, 5'b11000);
    chk("reset_mid_rd_data", a_rd, 8'h00);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(vr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
